mul_seq_ctrl: RTL and testbench
===============================

# mul_seq_ctrl

Multi-cycle sequencer for the ALU multiplier. It latches the operands of a MUL instruction held in execute and drives them into a registered multiplier with `LATENCY` pipeline stages. While the product is in flight it stalls the core pipeline, then returns the low and high product words with N/Z flags and a one-cycle `done`. It sits beside the ALU in the execute stage, between decode/hazard control and the multiplier instance.

## Interface
- `LATENCY`, default 4: register stages inside the multiplier, 0..15. 0 means purely combinational.
- `W`, default 32: operand width.
- `clk` input 1: single core clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: execute stage holds a MUL (ALUControl == 3'b111). Level, held until the instruction advances.
- `flush` input 1: execute-stage flush. Aborts any multiply in flight.
- `a`, `b` input W: source operands from the register file / forwarding path.
- `mul_a`, `mul_b` output W: registered operands to the multiplier.
- `mul_p` input 2W: multiplier product.
- `stall` output 1: freeze fetch/decode/execute.
- `done` output 1: one-cycle pulse; `result_lo`/`result_hi`/`flags` are valid this cycle.
- `result_lo`, `result_hi` output W: captured product halves.
- `flags` output 4: {N, Z, C, V}. N = `result_lo[W-1]`, Z = (`result_lo` == 0), C = 0, V = 0.

## Operation
- State machine states are IDLE, BUSY, DONE.
- Down-counter `cnt` is 4 bits wide.
- Reset (`reset_n` low, any time, including mid-multiply):
  - state IDLE, `cnt` = 0.
  - `mul_a`, `mul_b`, `result_lo`, `result_hi` = 0; `flags` = 0.
  - `done` = 0, `stall` = 0.
- IDLE:
  - If `start` && !`flush`: capture `a`/`b` into `mul_a`/`mul_b`, load `cnt` = LATENCY, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - `mul_a`/`mul_b` are held constant.
  - If `flush`: go to IDLE. No capture, no `done`.
  - Else if `cnt` == 0: capture `mul_p` into `result_lo`/`result_hi`, update `flags`, go to DONE.
  - Else decrement `cnt`.
- DONE:
  - `done` = 1 for exactly this cycle. `start` is ignored, because it belongs to the completing instruction.
  - Go unconditionally to IDLE.
- `stall` is combinational: (IDLE && `start` && !`flush`) || BUSY. It is 0 in DONE.
- `flush` has priority over `start` and over completion.
- Results and flags hold their last captured value until the next capture.

## Timing
- Cycle 0 is the cycle in which `start` is first seen in IDLE.
  - `stall` = 1 in cycles 0 .. LATENCY+1.
  - Operands appear on `mul_a`/`mul_b` from cycle 1.
  - Contract on `mul_p`: it must be valid in cycle 1+LATENCY. Capture happens at the end of that cycle.
  - DONE is cycle LATENCY+2. `done` = 1 and `stall` = 0, so the instruction writes back and advances.
- Total occupancy is LATENCY+2 cycles per MUL. With LATENCY = 0: stall in cycles 0–1, `done` in cycle 2.
- Back-to-back MULs: the second instruction enters execute in cycle LATENCY+3 (IDLE) and starts there. There is one idle-free gap only through DONE.
- A `flush` in BUSY cycle k means `stall` = 0 from cycle k+1 and `done` is never pulsed.
- `reset_n` deassertion is synchronised externally. The first active edge after release sees IDLE.

## Structure
- Shared package `mul_seq_pkg` holds:
  - state encoding (2 bits: IDLE = 0, BUSY = 1, DONE = 2),
  - `ALU_MUL` = 3'b111,
  - flag bit indices N = 3, Z = 2, C = 1, V = 0.
- No sub-module. The counter and FSM are inline.
- The multiplier is instantiated by the parent and connected via `mul_a`/`mul_b`/`mul_p`.

## Test plan
- LATENCY = 4, a = 7, b = 6, `start` held: `stall` high cycles 0–5, `done` in cycle 6, `result_lo` = 42, `result_hi` = 0, `flags` = 4'b0000.
- a = 32'hFFFF_FFFF (−1), b = 3: `result_lo` = 32'hFFFF_FFFD, `result_hi` = 32'h0000_0002 (unsigned product), N = 1, Z = 0.
- a = 0, b = 32'h1234: `result_lo` = 0, Z = 1, N = 0.
- `flush` asserted in BUSY cycle 2: `stall` = 0 from cycle 3, `done` is never asserted, results are unchanged from the prior value.
- `reset_n` pulled low in BUSY: all outputs are 0 immediately. After release, a new start completes normally with `done` at LATENCY+2.
- Two MULs back-to-back (3×5 then 4×4), each with `start` held until its `done`: `done` in cycles 6 and 13, results 15 and 16. `start` during DONE does not retrigger.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared definitions for the multi-cycle multiplier sequencer:
// state encoding, the MUL ALU opcode and the flag bit positions.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } mul_state_e;

  localparam logic [2:0] AluMul = 3'b111;

  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

endpackage

// File: rtl/mul_seq_ctrl.sv
// Sequencer for a registered multiplier: latches MUL operands, stalls the core
// while the product is in flight, then returns both product halves with N/Z flags.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned W       = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           flush,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_p,
  output logic           stall,
  output logic           done,
  output logic [W-1:0]   result_lo,
  output logic [W-1:0]   result_hi,
  output logic [3:0]     flags
);

  mul_state_e   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [W-1:0] mul_a_q, mul_a_d;
  logic [W-1:0] mul_b_q, mul_b_d;
  logic [W-1:0] res_lo_q, res_lo_d;
  logic [W-1:0] res_hi_q, res_hi_d;
  logic [3:0]   flags_q, flags_d;
  logic         accept;

  assign accept = (state_q == StIdle) && start && !flush;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    flags_d  = flags_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          mul_a_d = a;
          mul_b_d = b;
          cnt_d   = 4'(LATENCY);
          state_d = StBusy;
        end
      end
      StBusy: begin
        // Flush wins over completion: the aborted product is never captured.
        if (flush) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          res_lo_d        = mul_p[W-1:0];
          res_hi_d        = mul_p[2*W-1:W];
          flags_d         = '0;
          flags_d[FlagN]  = mul_p[W-1];
          flags_d[FlagZ]  = (mul_p[W-1:0] == '0);
          state_d         = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      // start seen here still belongs to the completing instruction.
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      flags_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      flags_q  <= flags_d;
    end
  end

  // Gated by reset so a held start cannot stall the core while in reset.
  assign stall     = reset_n && (accept || (state_q == StBusy));
  assign done      = (state_q == StDone);
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl with a LATENCY-stage registered multiplier model.
module tb_mul_seq_ctrl;

  localparam int unsigned Lat = 4;
  localparam int unsigned W   = 32;

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [3:0]   fl;
  } exp_t;

  logic           clk;
  logic           reset_n;
  logic           start;
  logic           flush;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic [2*W-1:0] mul_p;
  logic           stall;
  logic           done;
  logic [W-1:0]   result_lo;
  logic [W-1:0]   result_hi;
  logic [3:0]     flags;

  int   n_tests;
  int   n_fail;
  int   done_cnt;
  exp_t sb_q[$];
  exp_t last_exp;

  mul_seq_ctrl #(
    .LATENCY(Lat),
    .W      (W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .flush    (flush),
    .a        (a),
    .b        (b),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_p    (mul_p),
    .stall    (stall),
    .done     (done),
    .result_lo(result_lo),
    .result_hi(result_hi),
    .flags    (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered multiplier: product of the operands seen in cycle k appears in cycle k+Lat.
  logic [2*W-1:0] pipe [Lat];
  always @(posedge clk) begin
    pipe[0] <= {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
    for (int i = 1; i < Lat; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_p = pipe[Lat-1];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && done) begin
      exp_t e;
      done_cnt++;
      check_eq("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_eq("result_lo", 64'(result_lo), 64'(e.lo));
        check_eq("result_hi", 64'(result_hi), 64'(e.hi));
        check_eq("flags", 64'(flags), 64'(e.fl));
      end
    end
  end

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    exp_t           e;
    p    = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    e.lo = p[W-1:0];
    e.hi = p[2*W-1:W];
    e.fl = {p[W-1], (p[W-1:0] == '0), 2'b00};
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a MUL in the current cycle (cycle 0) and follows it to its DONE cycle;
  // start is left held so a following call models a back-to-back instruction.
  task automatic do_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    tick();
    a = x; b = y; start = 1'b1; flush = 1'b0;
    #1;
    e = model(x, y);
    sb_q.push_back(e);
    last_exp = e;
    check_eq("stall_c0", 64'(stall), 64'd1);
    for (int k = 1; k <= Lat + 1; k++) begin
      tick();
      a = ~x; b = ~y;
      #1;
      check_eq("stall_busy", 64'(stall), 64'd1);
      check_eq("done_busy", 64'(done), 64'd0);
      if (k == 1) begin
        check_eq("mul_a", 64'(mul_a), 64'(x));
        check_eq("mul_b", 64'(mul_b), 64'(y));
      end
    end
    tick();
    #1;
    check_eq("done_pulse", 64'(done), 64'd1);
    check_eq("stall_done", 64'(stall), 64'd0);
  endtask

  task automatic finish_op();
    tick();
    start = 1'b0;
    #1;
    check_eq("stall_after", 64'(stall), 64'd0);
    check_eq("done_after", 64'(done), 64'd0);
  endtask

  initial begin
    int cnt_snap;
    n_tests  = 0;
    n_fail   = 0;
    done_cnt = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    a        = '0;
    b        = '0;
    #2;
    check_eq("rst_stall", 64'(stall), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_mul_a", 64'(mul_a), 64'd0);
    check_eq("rst_lo", 64'(result_lo), 64'd0);
    check_eq("rst_hi", 64'(result_hi), 64'd0);
    check_eq("rst_flags", 64'(flags), 64'd0);
    repeat (3) tick();
    #2 reset_n = 1'b1;

    do_mul(32'd7, 32'd6);
    finish_op();
    do_mul(32'hFFFF_FFFF, 32'd3);
    finish_op();
    do_mul(32'd0, 32'h1234);
    finish_op();

    // Flush in BUSY cycle 2
    cnt_snap = done_cnt;
    tick();
    a = 32'd5; b = 32'd9; start = 1'b1;
    #1;
    check_eq("fl_stall_c0", 64'(stall), 64'd1);
    tick();
    tick();
    flush = 1'b1;
    #1;
    check_eq("fl_stall_c2", 64'(stall), 64'd1);
    tick();
    flush = 1'b0; start = 1'b0;
    #1;
    check_eq("fl_stall_c3", 64'(stall), 64'd0);
    repeat (Lat + 3) tick();
    check_eq("fl_no_done", 64'(done_cnt), 64'(cnt_snap));
    check_eq("fl_lo_kept", 64'(result_lo), 64'(last_exp.lo));
    check_eq("fl_flags_kept", 64'(flags), 64'(last_exp.fl));

    // Reset mid-multiply
    tick();
    a = 32'd11; b = 32'd13; start = 1'b1;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check_eq("mr_stall", 64'(stall), 64'd0);
    check_eq("mr_done", 64'(done), 64'd0);
    check_eq("mr_mul_a", 64'(mul_a), 64'd0);
    check_eq("mr_mul_b", 64'(mul_b), 64'd0);
    check_eq("mr_lo", 64'(result_lo), 64'd0);
    check_eq("mr_hi", 64'(result_hi), 64'd0);
    check_eq("mr_flags", 64'(flags), 64'd0);
    start = 1'b0;
    tick();
    #2 reset_n = 1'b1;
    do_mul(32'd9, 32'd9);
    finish_op();

    // Back-to-back with start held through DONE
    do_mul(32'd3, 32'd5);
    do_mul(32'd4, 32'd4);
    finish_op();

    repeat (4) tick();
    check_eq("done_count", 64'(done_cnt), 64'd6);
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
